// File: rtl/image_fetch_stream_pkg.sv
// Shared types and default geometry for the image fetch streamer.
package img_fetch_pkg;

  localparam int unsigned PIX_W          = 16;
  localparam int unsigned ADDR_W         = 16;
  localparam int unsigned IMG_W_DEF      = 224;
  localparam int unsigned IMG_H_DEF      = 224;
  localparam int unsigned FIFO_DEPTH_DEF = 4;

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_e;

  typedef struct packed {
    logic [PIX_W-1:0] data;
    logic             eol;
    logic             last;
  } fifo_entry_t;

endpackage

// File: rtl/image_fetch_stream_if.sv
// Control, memory-read and pixel-stream signals of the image fetch streamer.
interface image_fetch_stream_if;
  import img_fetch_pkg::*;

  logic              start;
  logic              busy;
  logic              done;
  logic              err;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic [PIX_W-1:0]  mem_pixel;
  logic              mem_valid;
  logic [PIX_W-1:0]  out_data;
  logic              out_valid;
  logic              out_ready;
  logic              out_eol;
  logic              out_last;

  modport master (
    input  start, mem_pixel, mem_valid, out_ready,
    output busy, done, err, mem_req, mem_addr, out_data, out_valid, out_eol, out_last
  );

  modport slave (
    output start, mem_pixel, mem_valid, out_ready,
    input  busy, done, err, mem_req, mem_addr, out_data, out_valid, out_eol, out_last
  );

endinterface

// File: rtl/image_fetch_stream_fifo.sv
// Small synchronous FIFO of tagged pixels; head is read straight from the register array.
module img_fetch_fifo
  import img_fetch_pkg::*;
#(
  parameter  int unsigned DEPTH = FIFO_DEPTH_DEF,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  fifo_entry_t      din_i,
  input  logic             pop_i,
  output fifo_entry_t      head_o,
  output logic [CNT_W-1:0] count_o,
  output logic             full_o,
  output logic             empty_o
);

  fifo_entry_t      mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full_q, empty_q;
  logic             do_push, do_pop;

  always_comb begin
    do_push = push_i && !full_q;
    do_pop  = pop_i && !empty_q;
    count_d = count_q;
    if (do_push && !do_pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (!do_push && do_pop) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  // Flags are registered from the next count so they carry no logic depth.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= din_i;
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      count_q <= count_d;
      full_q  <= (count_d == CNT_W'(DEPTH));
      empty_q <= (count_d == '0);
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign full_o  = full_q;
  assign empty_o = empty_q;

endmodule

// File: rtl/image_fetch_stream.sv
// Raster-order image memory requester that repackages read data as a tagged
// valid/ready pixel stream, throttled by credits so backpressure never drops a pixel.
module image_fetch_stream
  import img_fetch_pkg::*;
#(
  parameter int unsigned IMG_W      = IMG_W_DEF,
  parameter int unsigned IMG_H      = IMG_H_DEF,
  parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic clk,
  input  logic rst,
  image_fetch_stream_if.master bus
);

  localparam int unsigned TOTAL = IMG_W * IMG_H;
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned OCC_W = CNT_W + 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(TOTAL - 1);
  localparam logic [ADDR_W-1:0] LAST_COL  = ADDR_W'(IMG_W - 1);

  state_e            state_q;
  logic              busy_q, done_q, err_q;
  logic              mem_req_q, inflight_q;
  logic [ADDR_W-1:0] mem_addr_q, rx_cnt_q, col_q;

  fifo_entry_t       push_entry_c, head_c;
  logic              push_c, pop_c, last_pop_c, credit_c;
  logic [OCC_W-1:0]  occ_next_c;
  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_full, fifo_empty;

  // Next-cycle occupancy: entries after this edge plus the response that will be in flight.
  always_comb begin
    push_c            = inflight_q;
    push_entry_c.data = bus.mem_valid ? bus.mem_pixel : '0;
    push_entry_c.eol  = (col_q == LAST_COL);
    push_entry_c.last = (rx_cnt_q == LAST_ADDR);
    pop_c             = !fifo_empty && bus.out_ready;
    last_pop_c        = pop_c && head_c.last;
    occ_next_c        = OCC_W'(fifo_count) + OCC_W'(push_c) + OCC_W'(mem_req_q) - OCC_W'(pop_c);
    credit_c          = (occ_next_c < OCC_W'(FIFO_DEPTH));
  end

  img_fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push_c),
    .din_i   (push_entry_c),
    .pop_i   (pop_c),
    .head_o  (head_c),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      mem_req_q  <= 1'b0;
      inflight_q <= 1'b0;
      mem_addr_q <= '0;
      rx_cnt_q   <= '0;
      col_q      <= '0;
    end else begin
      done_q     <= 1'b0;
      inflight_q <= mem_req_q;

      // Every issued request yields exactly one beat; a missing response becomes a zero pixel.
      if (push_c) begin
        rx_cnt_q <= rx_cnt_q + ADDR_W'(1);
        col_q    <= (col_q == LAST_COL) ? '0 : col_q + ADDR_W'(1);
        if (!bus.mem_valid) begin
          err_q <= 1'b1;
        end
      end

      case (state_q)
        IDLE: begin
          if (bus.start) begin
            state_q    <= FETCH;
            busy_q     <= 1'b1;
            err_q      <= 1'b0;
            mem_req_q  <= 1'b1;
            mem_addr_q <= '0;
            rx_cnt_q   <= '0;
            col_q      <= '0;
          end
        end
        FETCH: begin
          if (mem_req_q && (mem_addr_q == LAST_ADDR)) begin
            state_q   <= DRAIN;
            mem_req_q <= 1'b0;
          end else begin
            if (mem_req_q) begin
              mem_addr_q <= mem_addr_q + ADDR_W'(1);
            end
            mem_req_q <= credit_c;
          end
        end
        DRAIN: begin
          if (last_pop_c) begin
            state_q <= DONE;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assert property (@(posedge clk) disable iff (rst) !(push_c && fifo_full))
    else $error("push into full pixel FIFO");

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.out_valid = !fifo_empty;
  assign bus.out_data  = head_c.data;
  assign bus.out_eol   = head_c.eol;
  assign bus.out_last  = head_c.last;

endmodule

// File: doc/image_fetch_stream.md
Name: image_fetch_stream

Overview:
- Requester side of the image memory read interface: on `start`, walks pixel addresses 0..IMG_W*IMG_H-1 in raster order.
- Issues one `mem_req`/`mem_addr` per cycle and captures the `mem_pixel`/`mem_valid` response, which arrives exactly one cycle later.
- Repackages pixels as a valid/ready stream with line and frame markers for the first conv block.
- Throttles requests with a small skid FIFO, so backpressure never loses a pixel.

Parameters:
- IMG_W, 224, pixels per line.
- IMG_H, 224, lines per frame. IMG_W*IMG_H must be ≤ 65536.
- FIFO_DEPTH, 4, output buffer entries. Power of 2, ≥ 2.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- start  in  1  single-cycle frame fetch request
- busy  out  1  frame in progress
- done  out  1  one-cycle pulse after last output handshake
- err  out  1  sticky: a response was missing
- mem_req  out  1  read request to image memory
- mem_addr  out  16  pixel address
- mem_pixel  in  16  read data, valid the cycle after mem_req
- mem_valid  in  1  read data qualifier
- out_data  out  16  pixel
- out_valid  out  1  stream valid
- out_ready  in  1  stream ready
- out_eol  out  1  qualifies beat: last pixel of a line
- out_last  out  1  qualifies beat: last pixel of frame

Behaviour:
- Reset: rst is asynchronous, active-high; clock is clk. All state cleared:
  - busy=0, done=0, err=0, mem_req=0, mem_addr=0, out_valid=0, out_eol=0, out_last=0, out_data=0.
  - FIFO empty, counters 0, state IDLE.
- State machine:
  - IDLE: `start` → FETCH; clear issue counter, receive counter and err. busy=1 from the next cycle.
  - FETCH: issue requests per the credit rule. After the request for address IMG_W*IMG_H-1 → DRAIN.
  - DRAIN: no requests. Wait for the final response to be pushed and the FIFO to empty through the last handshake → DONE.
  - DONE: done=1 for one cycle, busy=0 → IDLE.
  - `start` while busy, or in the DONE cycle, is ignored.
- Credit rule: mem_req (registered) asserts in a cycle only if (fifo_count + inflight) < FIFO_DEPTH.
  - inflight = 1 when mem_req was high the previous cycle.
  - mem_addr increments by 1 after each issued request. mem_addr is held when mem_req=0.
  - With out_ready held high, mem_req is continuous and throughput is 1 pixel/cycle.
- Response capture: the cycle after each mem_req=1, push one entry into the FIFO.
  - If mem_valid=1, push mem_pixel.
  - If mem_valid=0, push 16'h0000 and set err. Beat count is preserved and err stays set until the next accepted start.
  - mem_valid in a cycle with no outstanding request is ignored.
- Tags:
  - eol tag set when the receive column counter = IMG_W-1. Column wraps to 0.
  - last tag set on receive count IMG_W*IMG_H-1.
  - Tags travel with the data in the FIFO.
- Output:
  - out_valid = FIFO not empty. out_data/out_eol/out_last come from the FIFO head.
  - Pop on out_valid & out_ready.
  - Simultaneous push and pop leaves the count unchanged. Push to a full FIFO cannot occur by construction; assert this in sim.
  - out_data/out_eol/out_last hold stable while out_valid=1 and out_ready=0.
- Latency: start sampled at cycle 0 → mem_req=1, addr=0 at cycle 1 → response at cycle 2 → out_valid=1 at cycle 3.
- done pulses the cycle after the handshake of the out_last beat.
- Reset mid-frame: abort immediately and return to the reset values above. Any late mem_valid is ignored.

Decomposition:
- Package img_fetch_pkg holds:
  - the state enum (IDLE, FETCH, DRAIN, DONE);
  - default IMG_W/IMG_H/FIFO_DEPTH constants;
  - PIX_W=16 and ADDR_W=16;
  - the packed FIFO entry struct {data, eol, last}.
- One sub-module: img_fetch_fifo. This is a synchronous FIFO with async reset, plus count, full and empty outputs and a registered array with head read.

Test Plan:
- IMG_W=4, IMG_H=3, memory model holding addr+16'h100, out_ready=1 → 12 beats 0x100..0x10B:
  - 1 beat/cycle starting cycle 3;
  - out_eol on beats 3, 7, 11; out_last only on beat 11;
  - done one cycle after beat 11; err=0.
- Same config, out_ready toggling 1 cycle high / 3 low → identical data sequence with no drops or duplicates.
  - fifo_count never exceeds 4; mem_req stalls when count+inflight=4.
- Memory model withholds mem_valid for addr 5 → beat 5 = 0x0000, err=1 and stays high through done; all other beats are correct.
- Pulse start again at cycle 5 of a frame → ignored: exactly 12 beats and a single done.
- Assert rst at beat 6 → all outputs 0 in that cycle; a new start then produces a full clean 12-beat frame from 0x100.
- Default 224x224, out_ready=1 → 50176 beats; out_last on beat 50175; mem_addr peaks at 50175 (0xC3FF).
